// File: rtl/dma_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl_pkg
// Brief    : Shared types and defaults for the bus-master DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
package dma_ctrl_pkg;

    localparam int ADDR_N_DEF = 16;
    localparam int DATA_N_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_t;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_arb
// Brief    : Fixed-priority picker, lowest requesting index wins.
// Revision : 1.0 - initial release
// ============================================================================
module dma_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan downwards so the lowest requester is the last one assigned.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl
// Brief    : Multi-channel page-to-register DMA that stalls the 6502 core.
// Revision : 1.0 - initial release
// ============================================================================
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int                         ADDR_N    = ADDR_N_DEF,
    parameter int                         DATA_N    = DATA_N_DEF,
    parameter int                         CHANNELS  = 2,
    parameter int                         LEN       = 256,
    parameter logic [ADDR_N-1:0]          TRIG_BASE = 16'h4014,
    parameter logic [CHANNELS*ADDR_N-1:0] DST_ADDR  = {16'h2007, 16'h2004}
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [ADDR_N-1:0]   cpu_addr,
    input  logic [DATA_N-1:0]   cpu_dout,
    input  logic                cpu_we,
    output logic                cpu_rdy,
    input  logic                halt_ack,
    output logic                dma_oe,
    output logic [ADDR_N-1:0]   dma_addr,
    output logic                dma_we,
    output logic [DATA_N-1:0]   dma_dout,
    input  logic [DATA_N-1:0]   bus_din,
    output logic                busy,
    output logic [CHANNELS-1:0] overrun
);

    localparam int               CNT_W  = $clog2(LEN);
    localparam int               IDX_W  = idx_width(CHANNELS);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LEN - 1);

    dma_state_t          state_q;
    logic                parity_q;
    logic                align_extra_q;
    logic [CNT_W-1:0]    idx_q;
    logic [IDX_W-1:0]    ch_q;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    logic [DATA_N-1:0]   page_q [CHANNELS];
    logic [DATA_N-1:0]   page_d [CHANNELS];

    logic                cpu_rdy_q, dma_oe_q, dma_we_q, busy_q;
    logic [ADDR_N-1:0]   dma_addr_q;
    logic [DATA_N-1:0]   dma_dout_q;

    logic [CHANNELS-1:0] trig, clr, arb_req, gnt;
    logic [IDX_W-1:0]    sel;
    logic                any;
    logic                last_beat;
    logic [DATA_N-1:0]   sel_page;
    logic [ADDR_N-1:0]   dst_tab [CHANNELS];
    logic [ADDR_N-1:0]   cur_src, inc_src;

    function automatic logic [ADDR_N-1:0] src_addr(input logic [DATA_N-1:0] pg,
                                                   input logic [CNT_W-1:0]  ix);
        return ADDR_N'({pg, {DATA_N{1'b0}}}) + ADDR_N'(ix);
    endfunction

    assign last_beat = (state_q == ST_WRITE) && (idx_q == C_LAST);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            assign trig[c]    = cpu_we && (cpu_addr == TRIG_BASE + ADDR_N'(c));
            assign clr[c]     = last_beat && (ch_q == IDX_W'(c));
            assign dst_tab[c] = DST_ADDR[c*ADDR_N +: ADDR_N];
            // A page is only accepted while its channel is free.
            assign page_d[c]  = (trig[c] && !pend_q[c]) ? cpu_dout : page_q[c];
        end
    endgenerate

    assign pend_d  = (pend_q | trig) & ~clr;
    assign ovr_d   = ovr_q | (trig & pend_q);
    assign arb_req = (state_q == ST_IDLE) ? pend_q : pend_d;

    dma_arb #(
        .N     (CHANNELS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (arb_req),
        .gnt_o (gnt),
        .idx_o (sel),
        .any_o (any)
    );

    always_comb begin
        sel_page = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt[i]) sel_page = sel_page | page_d[i];
        end
    end

    assign cur_src = src_addr(page_q[ch_q], idx_q);
    assign inc_src = src_addr(page_q[ch_q], idx_q + 1'b1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            parity_q      <= 1'b0;
            align_extra_q <= 1'b0;
            idx_q         <= '0;
            ch_q          <= '0;
            pend_q        <= '0;
            ovr_q         <= '0;
            busy_q        <= 1'b0;
            cpu_rdy_q     <= 1'b1;
            dma_oe_q      <= 1'b0;
            dma_we_q      <= 1'b0;
            dma_addr_q    <= '0;
            dma_dout_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) page_q[i] <= '0;
        end else begin
            parity_q <= ~parity_q;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            busy_q   <= |pend_d;
            for (int i = 0; i < CHANNELS; i++) page_q[i] <= page_d[i];

            case (state_q)
                ST_IDLE: begin
                    if (|pend_q) begin
                        state_q   <= ST_HALT;
                        ch_q      <= sel;
                        cpu_rdy_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (halt_ack) begin
                        state_q       <= ST_ALIGN;
                        align_extra_q <= ~parity_q;
                        dma_oe_q      <= 1'b1;
                        dma_we_q      <= 1'b0;
                        dma_addr_q    <= cur_src;
                    end
                end
                ST_ALIGN: begin
                    if (align_extra_q) align_extra_q <= 1'b0;
                    else               state_q       <= ST_READ;
                end
                ST_READ: begin
                    state_q    <= ST_WRITE;
                    dma_dout_q <= bus_din;
                    dma_addr_q <= dst_tab[ch_q];
                    dma_we_q   <= 1'b1;
                end
                ST_WRITE: begin
                    dma_we_q <= 1'b0;
                    if (!last_beat) begin
                        idx_q      <= idx_q + 1'b1;
                        state_q    <= ST_READ;
                        dma_addr_q <= inc_src;
                    end else begin
                        idx_q <= '0;
                        // Queued channels chain without re-halting the CPU.
                        if (any) begin
                            ch_q       <= sel;
                            state_q    <= ST_READ;
                            dma_addr_q <= src_addr(sel_page, '0);
                        end else begin
                            state_q   <= ST_DONE;
                            dma_oe_q  <= 1'b0;
                            cpu_rdy_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdy  = cpu_rdy_q;
    assign dma_oe   = dma_oe_q;
    assign dma_we   = dma_we_q;
    assign dma_addr = dma_addr_q;
    assign dma_dout = dma_dout_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_ctrl
// Brief    : Self-checking bench for dma_ctrl against a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_ctrl;

    localparam int LEN = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset;
    logic [15:0] cpu_addr, dma_addr, cpu_addr2, dma_addr2;
    logic [7:0]  cpu_dout, dma_dout, bus_din, cpu_dout2, dma_dout2, bus_din2;
    logic        cpu_we, cpu_rdy, halt_ack, dma_oe, dma_we, busy;
    logic        cpu_we2, cpu_rdy2, halt_ack2, dma_oe2, dma_we2, busy2;
    logic [1:0]  overrun, overrun2;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
    endfunction

    function automatic logic [15:0] srcf(input logic [7:0] pg, input int ix);
        return {pg, 8'h00} + 16'(ix);
    endfunction

    assign bus_din  = memf(dma_addr);
    assign bus_din2 = memf(dma_addr2);

    dma_ctrl dut (
        .clk(clk), .n_reset(n_reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .halt_ack(halt_ack), .dma_oe(dma_oe),
        .dma_addr(dma_addr), .dma_we(dma_we), .dma_dout(dma_dout), .bus_din(bus_din),
        .busy(busy), .overrun(overrun)
    );

    dma_ctrl #(.LEN(512)) dut2 (
        .clk(clk), .n_reset(n_reset), .cpu_addr(cpu_addr2), .cpu_dout(cpu_dout2),
        .cpu_we(cpu_we2), .cpu_rdy(cpu_rdy2), .halt_ack(halt_ack2), .dma_oe(dma_oe2),
        .dma_addr(dma_addr2), .dma_we(dma_we2), .dma_dout(dma_dout2), .bus_din(bus_din2),
        .busy(busy2), .overrun(overrun2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level model ----------------
    // Phases: 0 idle, 1 CPU being halted, 2 alignment, 3 data beats, 4 done.
    int          m_ph, m_left, m_beat, m_ch, m_edges;
    logic [1:0]  m_pend, m_ovr;
    logic [7:0]  m_page [2];
    logic [15:0] DSTS [2] = '{16'h2004, 16'h2007};

    function automatic int lowest(input logic [1:0] p);
        return p[0] ? 0 : 1;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_ph = 0; m_left = 0; m_beat = 0; m_ch = 0; m_edges = 0;
            m_pend = '0; m_ovr = '0; m_page[0] = '0; m_page[1] = '0;
        end else begin
            logic [1:0] p0;
            p0 = m_pend;
            for (int c = 0; c < 2; c++) begin
                if (cpu_we && cpu_addr == 16'h4014 + 16'(c)) begin
                    if (p0[c]) m_ovr[c] = 1'b1;
                    else begin m_pend[c] = 1'b1; m_page[c] = cpu_dout; end
                end
            end
            case (m_ph)
                0: if (p0 != 0) begin m_ph = 1; m_ch = lowest(p0); end
                1: if (halt_ack) begin m_ph = 2; m_left = ((m_edges + 1) % 2 == 1) ? 2 : 1; end
                2: begin m_left--; if (m_left == 0) begin m_ph = 3; m_beat = 0; end end
                3: begin
                    if (m_beat == 2 * LEN - 1) begin
                        m_pend[m_ch] = 1'b0;
                        if (m_pend != 0) begin m_ch = lowest(m_pend); m_beat = 0; end
                        else m_ph = 4;
                    end else m_beat++;
                end
                default: m_ph = 0;
            endcase
            m_edges++;
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (n_reset && chk_en) begin
            logic        e_oe, e_we;
            logic [15:0] e_addr;
            e_oe   = (m_ph == 2 || m_ph == 3);
            e_we   = (m_ph == 3) && (m_beat % 2 == 1);
            e_addr = e_we ? DSTS[m_ch] : srcf(m_page[m_ch], (m_ph == 3) ? m_beat / 2 : 0);
            chk("m_cpu_rdy", cpu_rdy, (m_ph == 0 || m_ph == 4));
            chk("m_dma_oe", dma_oe, e_oe);
            chk("m_dma_we", dma_we, e_we);
            chk("m_busy", busy, (m_pend != 0));
            chk("m_overrun", overrun, m_ovr);
            if (e_oe) chk("m_dma_addr", dma_addr, e_addr);
            if (e_we) chk("m_dma_dout", dma_dout, memf(srcf(m_page[m_ch], m_beat / 2)));
        end
    end

    // ---------------- bus monitors ----------------
    logic [15:0] q_src[$], q_dst[$], q2_src[$], q2_dst[$];
    int          q_cyc[$];
    logic [15:0] prev_addr, prev_addr2;
    int          stall = 0, cyc = 0, bad2 = 0;

    always @(negedge clk) begin
        if (n_reset) begin
            if (dma_we) begin q_src.push_back(prev_addr); q_dst.push_back(dma_addr); q_cyc.push_back(cyc); end
            if (dma_we2) begin
                q2_src.push_back(prev_addr2); q2_dst.push_back(dma_addr2);
                if (dma_dout2 !== memf(prev_addr2)) bad2++;
            end
            prev_addr  = dma_addr;
            prev_addr2 = dma_addr2;
            if (!cpu_rdy) stall++;
            cyc++;
        end
    end

    // CPU side: acknowledges the halt one cycle after it sees cpu_rdy low.
    logic seen;
    initial begin
        halt_ack = 1'b0; seen = 1'b0;
        forever begin
            @(negedge clk); #1;
            halt_ack = seen;
            seen     = !cpu_rdy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int trig_cyc;

    task automatic trig(input int ch, input logic [7:0] pg);
        @(negedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 16'h4014 + 16'(ch); cpu_dout = pg; trig_cyc = cyc;
        @(negedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h0000;
    endtask

    task automatic clear_log();
        q_src.delete(); q_dst.delete(); q_cyc.delete(); stall = 0;
    endtask

    task automatic wait_writes(input int n, input string name);
        bit ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (q_dst.size() >= n) ok = 1;
            else begin @(negedge clk); #1; end
        end
        if (!ok) chk(name, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk); #1;
            if (!busy && cpu_rdy) ok = 1;
        end
        if (!ok) chk(name, 0, 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    int s1, s2, p1;

    initial begin
        n_reset = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;
        cpu_we2 = 1'b0; cpu_addr2 = '0; cpu_dout2 = '0; halt_ack2 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_rdy", cpu_rdy, 1);
        chk("rst_dma_oe", dma_oe, 0);
        chk("rst_dma_we", dma_we, 0);
        chk("rst_dma_addr", dma_addr, 0);
        chk("rst_dma_dout", dma_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk); #1;
        n_reset = 1'b1; chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single OAM-style transfer from page 02.
        clear_log();
        trig(0, 8'h02);
        chk("busy_after_trig", busy, 1);
        chk("rdy_before_halt", cpu_rdy, 1);
        @(negedge clk); #1;
        chk("rdy_low_T1", cpu_rdy, 0);
        wait_writes(256, "timeout_t1");
        wait_idle("idle_t1");
        s1 = stall; p1 = trig_cyc % 2;
        chk("t1_count", q_dst.size(), 256);
        chk("t1_src_first", q_src[0], 16'h0200);
        chk("t1_src_last", q_src[255], 16'h02FF);
        chk("t1_dst_first", q_dst[0], 16'h2004);
        chk("t1_dst_last", q_dst[255], 16'h2004);
        chk("t1_stall_range", (s1 == 515 || s1 == 516), 1);

        // Same transfer triggered on the opposite cycle parity.
        for (int i = 0; i < 3 && ((cyc + 1) % 2) == p1; i++) begin @(negedge clk); #1; end
        clear_log();
        trig(0, 8'h02);
        wait_writes(256, "timeout_t2");
        wait_idle("idle_t2");
        s2 = stall;
        chk("t2_trig_parity", (trig_cyc % 2) != p1, 1);
        chk("t2_stall_sum", s1 + s2, 1031);
        chk("t2_stall_diff", (s1 > s2) ? s1 - s2 : s2 - s1, 1);

        // Both channels on consecutive cycles.
        clear_log();
        @(negedge clk); #1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h03;
        @(negedge clk); #1; cpu_addr = 16'h4015; cpu_dout = 8'h05;
        @(negedge clk); #1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        wait_writes(512, "timeout_t3");
        wait_idle("idle_t3");
        chk("t3_count", q_dst.size(), 512);
        chk("t3_src0", q_src[0], 16'h0300);
        chk("t3_dst0", q_dst[0], 16'h2004);
        chk("t3_src256", q_src[256], 16'h0500);
        chk("t3_dst256", q_dst[256], 16'h2007);
        chk("t3_src511", q_src[511], 16'h05FF);
        chk("t3_chain_gap", q_cyc[256] - q_cyc[255], 2);

        // Re-trigger of an active channel is dropped.
        clear_log();
        trig(0, 8'h02);
        wait_writes(10, "timeout_t4a");
        trig(0, 8'h07);
        chk("t4_overrun", overrun, 2'b01);
        wait_writes(256, "timeout_t4b");
        wait_idle("idle_t4");
        repeat (30) @(negedge clk);
        #1;
        chk("t4_count", q_dst.size(), 256);
        chk("t4_src10", q_src[10], 16'h020A);
        chk("t4_src_last", q_src[255], 16'h02FF);
        chk("t4_busy", busy, 0);

        // Reset in the middle of a transfer.
        clear_log();
        trig(1, 8'h04);
        wait_writes(100, "timeout_t5a");
        @(negedge clk); #1;
        n_reset = 1'b0;
        #1;
        chk("t5_rdy", cpu_rdy, 1);
        chk("t5_oe", dma_oe, 0);
        chk("t5_busy", busy, 0);
        chk("t5_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        #1;
        n_reset = 1'b1;
        clear_log();
        trig(0, 8'h06);
        wait_writes(256, "timeout_t5b");
        wait_idle("idle_t5");
        chk("t5_count", q_dst.size(), 256);
        chk("t5_src0", q_src[0], 16'h0600);
        chk("t5_dst0", q_dst[0], 16'h2004);

        // Page FF with a 512-byte transfer wraps the source address.
        @(negedge clk); #1; cpu_we2 = 1'b1; cpu_addr2 = 16'h4014; cpu_dout2 = 8'hFF;
        @(negedge clk); #1; cpu_we2 = 1'b0; cpu_addr2 = 16'h0000;
        begin
            bit ok = 0;
            for (int i = 0; i < 5000 && !ok; i++) begin
                @(negedge clk); #1;
                if (q2_dst.size() >= 512 && !busy2) ok = 1;
            end
            if (!ok) chk("timeout_t6", 0, 1);
        end
        chk("t6_count", q2_dst.size(), 512);
        chk("t6_src0", q2_src[0], 16'hFF00);
        chk("t6_src255", q2_src[255], 16'hFFFF);
        chk("t6_src256", q2_src[256], 16'h0000);
        chk("t6_src511", q2_src[511], 16'h00FF);
        chk("t6_dst0", q2_dst[0], 16'h2004);
        chk("t6_data", bad2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
